cpu4_dmem_responder: RTL and testbench

CPU4_DMEM_RESPONDER -- requirements
Module: cpu4_dmem_responder

---
 rtl/cpu4_dmem_responder.sv | 142 ++++++++++++++
 tb/tb_cpu4_dmem_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpu4_dmem_responder.sv
// Single-port 32-bit data memory responder for the cpu4 core: IDLE -> (WAIT) -> RESP handshake.
// Define CPU4_DMEM_WAIT_EN to compile in the WAIT state and its WAIT_CYCLES down-counter.
module cpu4_dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef CPU4_DMEM_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam bit USE_WAIT = (WAIT_CYCLES > 0);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

  state_t state;

  logic [ADDR_W+1:0] cap_addr;
  logic              cap_we;
  logic [31:0]       cap_wdata;

  logic [ADDR_W+1:0] acc_addr;
  logic              acc_we;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_index;
  logic              acc_mis;
  logic              commit;

  logic [31:0] mem [DEPTH];

`ifdef CPU4_DMEM_WAIT_EN
  logic [3:0] cnt;
`endif

  // Only the word-index and byte-offset bits of the address matter; the rest wrap away.
  logic unused_bits;
`ifdef CPU4_DMEM_WAIT_EN
  assign unused_bits = ^aluout[31:ADDR_W+2];
`else
  assign unused_bits = ^{aluout[31:ADDR_W+2], 4'(WAIT_CYCLES)};
`endif

  // A zero-wait access commits on the same edge that captures it, so it must use live inputs.
  always_comb begin
    if (state == IDLE) begin
      acc_addr  = aluout[ADDR_W+1:0];
      acc_we    = memwrite;
      acc_wdata = writedata;
    end else begin
      acc_addr  = cap_addr;
      acc_we    = cap_we;
      acc_wdata = cap_wdata;
    end
  end

  assign acc_index = acc_addr[ADDR_W+1:2];
  assign acc_mis   = (acc_addr[1:0] != 2'b00);

`ifdef CPU4_DMEM_WAIT_EN
  assign commit = ((state == IDLE) && req && !USE_WAIT) || ((state == WAIT) && (cnt == 4'd0));
  assign stall  = ((state == IDLE) && req) || (state == WAIT);
`else
  assign commit = (state == IDLE) && req;
  assign stall  = (state == IDLE) && req;
`endif

  // Storage is never cleared; gating with reset keeps an access that is aborted by reset from landing.
  always_ff @(posedge clk) begin
    if (commit && reset && acc_we && !acc_mis) begin
      mem[acc_index] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cap_addr   <= '0;
      cap_we     <= 1'b0;
      cap_wdata  <= '0;
      readdata   <= '0;
      misaligned <= 1'b0;
`ifdef CPU4_DMEM_WAIT_EN
      cnt        <= 4'd0;
`endif
    end else begin
      misaligned <= 1'b0;
      if (commit) begin
        misaligned <= acc_mis;
        if (acc_mis) begin
          readdata <= '0;
        end else if (acc_we) begin
          readdata <= acc_wdata;
        end else begin
          readdata <= mem[acc_index];
        end
      end

      case (state)
        IDLE: begin
          if (req) begin
            cap_addr  <= aluout[ADDR_W+1:0];
            cap_we    <= memwrite;
            cap_wdata <= writedata;
`ifdef CPU4_DMEM_WAIT_EN
            if (USE_WAIT) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state <= RESP;
            end
`else
            state <= RESP;
`endif
          end
        end
`ifdef CPU4_DMEM_WAIT_EN
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`endif
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu4_dmem_responder.sv
// Directed bench for cpu4_dmem_responder: transaction-level memory model checked every cycle,
// plus literal expectations on load results, stall lengths and reset behaviour.
module tb_cpu4_dmem_responder;

  localparam int ADDR_W      = 8;
  localparam int WAIT_CYCLES = 2;
`ifdef CPU4_DMEM_WAIT_EN
  localparam int W = WAIT_CYCLES;
`else
  localparam int W = 0;
`endif
  localparam int DEPTH = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_mem [DEPTH];
  logic        exp_stall;
  logic        exp_mis;
  logic [31:0] exp_rd;
  bit          check_en = 1'b0;
  int          stall_seen;

  always #5 clk = ~clk;

  cpu4_dmem_responder #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .memwrite   (memwrite),
    .aluout     (aluout),
    .writedata  (writedata),
    .readdata   (readdata),
    .stall      (stall),
    .misaligned (misaligned)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Cycle-by-cycle comparison against the transaction model, away from the rising edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("stall", {31'b0, stall}, {31'b0, exp_stall});
      checkOutput("misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
      checkOutput("readdata", readdata, exp_rd);
      if (stall) stall_seen++;
    end
  end

  function automatic int word_index(input logic [31:0] addr);
    return int'((addr / 32'd4) % DEPTH);
  endfunction

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the edge leaving RESP.
  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] data,
                               input bit has_lit, input logic [31:0] lit, input string name);
    logic [31:0] result;
    bit          mis;
    mis = (addr % 32'd4) != 32'd0;
    if (mis) begin
      result = 32'h0;
    end else if (we) begin
      mdl_mem[word_index(addr)] = data;
      result = data;
    end else begin
      result = mdl_mem[word_index(addr)];
    end

    req = 1'b1; memwrite = we; aluout = addr; writedata = data;
    exp_stall = 1'b1; exp_mis = 1'b0;
    stall_seen = 0;
    for (int k = 0; k < W; k++) begin
      @(posedge clk); #1;
      memwrite = 1'($urandom_range(0, 1)); aluout = $urandom; writedata = $urandom;
    end
    @(posedge clk); #1;
    req = 1'b0; memwrite = 1'b0; aluout = $urandom; writedata = $urandom;
    exp_stall = 1'b0; exp_mis = mis; exp_rd = result;
    @(negedge clk); #1;
    checkOutput({name, "_stallcycles"}, 32'(stall_seen), 32'(1 + W));
    if (has_lit) checkOutput({name, "_result"}, readdata, lit);
    @(posedge clk); #1;
    exp_mis = 1'b0;
  endtask

  // Starts a write, then pulls reset before it can complete.
  task automatic abortWrite(input logic [31:0] addr, input logic [31:0] data);
    req = 1'b1; memwrite = 1'b1; aluout = addr; writedata = data;
    exp_stall = 1'b1; exp_mis = 1'b0;
    if (W > 0) begin
      @(posedge clk); #1;
    end
    #1;
    reset = 1'b0; req = 1'b0; memwrite = 1'b0;
    exp_stall = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
    #1;
    checkOutput("abort_stall", {31'b0, stall}, 32'h0);
    checkOutput("abort_readdata", readdata, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0;
    exp_stall = 1'b0; exp_mis = 1'b0; exp_rd = 32'h0;
    check_en = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idleCycles(10);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);

    applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, "wr_10");
    applyStimulus(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, "rd_10");
    applyStimulus(1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'h1234_5678, "wr_400");
    applyStimulus(1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1234_5678, "rd_0_wrap");
    applyStimulus(1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 1'b1, 32'h0,         "wr_mis");
    applyStimulus(1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF, "rd_10_after");
    applyStimulus(1'b0, 32'h0000_0002, 32'h0,         1'b1, 32'h0,         "rd_mis");
    idleCycles(2);
    applyStimulus(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, "wr_20");
    abortWrite(32'h0000_0020, 32'h1111_1111);
    applyStimulus(1'b0, 32'h0000_0020, 32'h0,         1'b1, 32'hA5A5_A5A5, "rd_20");
    applyStimulus(1'b1, 32'h0000_0004, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, "wr_4");
    applyStimulus(1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h1234_5678, "b2b_rd_0");
    applyStimulus(1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'hCAFE_F00D, "b2b_rd_4");
    applyStimulus(1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, "wr_3fc");
    applyStimulus(1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0BAD_F00D, "rd_top_wrap");
    applyStimulus(1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h0,         "rd_10_model");
    idleCycles(3);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
